// File: rtl/pwr_cntr_reader_pkg.sv
// Shared definitions for the power-counter reader: scan FSM encodings and the
// default memory geometry used by both the counter memory and the reader.
package pwr_cntr_reader_pkg;

  localparam int PWR_NDIR     = 1;
  localparam int PWR_NUM_CNTR = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_FINISH = 3'd4
  } pwr_state_e;

endpackage

// File: rtl/pwr_accum.sv
// Scratch accumulator for one scan: running total plus busiest counter (strict >,
// so ties keep the lower index). Cleared by the scan start; unknown samples are skipped.
module pwr_accum
  import pwr_cntr_reader_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             smp_vld,
  input  logic [IW-1:0]    smp_idx,
  input  logic [DW-1:0]    smp_dat,
  output logic [DW+IW-1:0] sum,
  output logic [IW-1:0]    max_idx,
  output logic [DW-1:0]    max_val
);

  logic [DW+IW-1:0] sum_q, sum_d;
  logic [IW-1:0]    max_idx_q, max_idx_d;
  logic [DW-1:0]    max_val_q, max_val_d;
  logic             dat_ok;

  always_comb begin
    sum_d     = sum_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    // A floating or undriven bus contributes nothing rather than poisoning the total
    dat_ok    = !$isunknown(smp_dat);
    if (clr) begin
      sum_d     = '0;
      max_idx_d = '0;
      max_val_d = '0;
    end else if (smp_vld && dat_ok) begin
      sum_d = sum_q + (DW+IW)'(smp_dat);
      if (smp_dat > max_val_q) begin
        max_val_d = smp_dat;
        max_idx_d = smp_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      sum_q     <= sum_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign sum     = sum_q;
  assign max_idx = max_idx_q;
  assign max_val = max_val_q;

endmodule

// File: rtl/pwr_cntr_reader.sv
// Bus master that walks the power-counter memory, reporting total and busiest counter.
// Define PWR_CLR_EN to zero each counter right after reading it (read-and-reset).
module pwr_cntr_reader
  import pwr_cntr_reader_pkg::*;
#(
  parameter int NDIR  = PWR_NDIR,
  parameter int NCNTR = PWR_NUM_CNTR,
  parameter int DW    = 32
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             START,
  output logic [NDIR:0]    dir,
  output logic             LE,
  inout  wire  [DW-1:0]    dato,
  output logic             BUSY,
  output logic             DONE,
  output logic [DW+NDIR:0] TOTAL,
  output logic [NDIR:0]    MAX_IDX,
  output logic [DW-1:0]    MAX_VAL
);

  localparam int IW = NDIR + 1;

  pwr_state_e       state_q, state_d, adv_state;
  logic [IW-1:0]    idx_q, idx_d, adv_idx;
  logic             done_q, done_d;
  logic [DW+IW-1:0] total_q, total_d;
  logic [IW-1:0]    max_idx_q, max_idx_d;
  logic [DW-1:0]    max_val_q, max_val_d;
  logic             acc_clr, smp_vld, last;
  logic [DW+IW-1:0] acc_sum;
  logic [IW-1:0]    acc_idx;
  logic [DW-1:0]    acc_val;

  pwr_accum #(.DW(DW), .IW(IW)) u_accum (
    .clk     (CLK),
    .rst_n   (RESET_L),
    .clr     (acc_clr),
    .smp_vld (smp_vld),
    .smp_idx (idx_q),
    .smp_dat (dato),
    .sum     (acc_sum),
    .max_idx (acc_idx),
    .max_val (acc_val)
  );

  always_comb begin
    last      = (idx_q == IW'(NCNTR - 1));
    adv_state = last ? ST_FINISH : ST_SETUP;
    adv_idx   = last ? idx_q : idx_q + IW'(1);

    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    acc_clr   = 1'b0;
    smp_vld   = 1'b0;
    total_d   = total_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETUP;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      ST_SETUP:  state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        smp_vld = 1'b1;
`ifdef PWR_CLR_EN
        state_d = ST_CLEAR;
`else
        state_d = adv_state;
        idx_d   = adv_idx;
`endif
      end
`ifdef PWR_CLR_EN
      ST_CLEAR: begin
        state_d = adv_state;
        idx_d   = adv_idx;
      end
`endif
      ST_FINISH: begin
        // Results and the DONE pulse land together on the edge leaving FINISH
        state_d   = ST_IDLE;
        idx_d     = '0;
        done_d    = 1'b1;
        total_d   = acc_sum;
        max_idx_d = acc_idx;
        max_val_d = acc_val;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      total_q   <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      total_q   <= total_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  // dir follows idx, which only moves on edges where LE is (or returns to) 1
  assign dir     = idx_q;
  assign BUSY    = (state_q == ST_SETUP) || (state_q == ST_SAMPLE) || (state_q == ST_CLEAR);
  assign DONE    = done_q;
  assign TOTAL   = total_q;
  assign MAX_IDX = max_idx_q;
  assign MAX_VAL = max_val_q;

`ifdef PWR_CLR_EN
  assign LE   = (state_q != ST_CLEAR);
  assign dato = LE ? {DW{1'bz}} : {DW{1'b0}};
`else
  assign LE   = 1'b1;
`endif

endmodule

// File: tb/tb_pwr_cntr_reader.sv
// Directed bench for pwr_cntr_reader with a behavioural counter memory on dir/LE/dato.
module tb_pwr_cntr_reader;

  localparam int NDIR  = 1;
  localparam int NCNTR = 3;
  localparam int DW    = 32;
`ifdef PWR_CLR_EN
  localparam int PER = 3;
`else
  localparam int PER = 2;
`endif
  localparam int LAT   = PER * NCNTR + 1;
  localparam int GAP   = PER * NCNTR + 2;
  localparam int LOWS  = (PER == 3) ? NCNTR : 0;

  logic             CLK = 1'b0;
  logic             RESET_L = 1'b0;
  logic             START = 1'b0;
  logic [NDIR:0]    dir;
  logic             LE;
  wire  [DW-1:0]    dato;
  logic             BUSY, DONE;
  logic [DW+NDIR:0] TOTAL;
  logic [NDIR:0]    MAX_IDX;
  logic [DW-1:0]    MAX_VAL;

  logic [DW-1:0] mem    [4];
  logic [DW-1:0] ld_val [4];
  logic          ld_stb = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  pwr_cntr_reader #(.NDIR(NDIR), .NCNTR(NCNTR), .DW(DW)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .START   (START),
    .dir     (dir),
    .LE      (LE),
    .dato    (dato),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .TOTAL   (TOTAL),
    .MAX_IDX (MAX_IDX),
    .MAX_VAL (MAX_VAL)
  );

  always #5 CLK = ~CLK;

  assign dato = LE ? mem[dir] : {DW{1'bz}};

  always @(posedge CLK) begin
    if (ld_stb) begin
      for (int i = 0; i < 4; i++) mem[i] <= ld_val[i];
    end
`ifdef PWR_CLR_EN
    else if (LE == 1'b0) begin
      mem[dir] <= dato;
    end
`endif
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    ld_val[0] = a; ld_val[1] = b; ld_val[2] = c; ld_val[3] = '0;
    ld_stb = 1'b1;
    @(posedge CLK); #1;
    ld_stb = 1'b0;
  endtask

  task automatic run_scan(input string tag, input logic [DW+NDIR:0] e_tot,
                          input logic [NDIR:0] e_idx, input logic [DW-1:0] e_val);
    int cyc;
    int lows;
    cyc  = 0;
    lows = 0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check_eq({tag, "_busy"}, 64'(BUSY), 64'd1);
    while (!DONE && cyc < 100) begin
      if (LE == 1'b0) lows++;
      @(posedge CLK); #1;
      cyc++;
    end
    check_eq({tag, "_lat"},   64'(cyc), 64'(LAT));
    check_eq({tag, "_le0"},   64'(lows), 64'(LOWS));
    check_eq({tag, "_total"}, 64'(TOTAL), 64'(e_tot));
    check_eq({tag, "_idx"},   64'(MAX_IDX), 64'(e_idx));
    check_eq({tag, "_val"},   64'(MAX_VAL), 64'(e_val));
    check_eq({tag, "_busy0"}, 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    check_eq({tag, "_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int dones;
    int t1;
    int t2;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_dir",   64'(dir), 64'd0);
    check_eq("rst_le",    64'(LE), 64'd1);
    check_eq("rst_busy",  64'(BUSY), 64'd0);
    check_eq("rst_done",  64'(DONE), 64'd0);
    check_eq("rst_total", 64'(TOTAL), 64'd0);
    check_eq("rst_idx",   64'(MAX_IDX), 64'd0);
    check_eq("rst_val",   64'(MAX_VAL), 64'd0);
    RESET_L = 1'b1;

    load_mem(32'd5, 32'd9, 32'd2);
    run_scan("s592", 34'd16, 2'd1, 32'd9);

    load_mem(32'd7, 32'd7, 32'd0);
    run_scan("tie", 34'd14, 2'd0, 32'd7);

    load_mem(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_scan("ones", 34'h2_FFFF_FFFD, 2'd0, 32'hFFFF_FFFF);

`ifdef PWR_CLR_EN
    load_mem(32'd3, 32'd4, 32'd5);
    run_scan("clr1", 34'd12, 2'd2, 32'd5);
    check_eq("clr_m0", 64'(mem[0]), 64'd0);
    check_eq("clr_m1", 64'(mem[1]), 64'd0);
    check_eq("clr_m2", 64'(mem[2]), 64'd0);
    run_scan("clr2", 34'd0, 2'd0, 32'd0);
`endif

    // Reset in SAMPLE of index 1: the cycle after edge k+3
    load_mem(32'd5, 32'd9, 32'd2);
    run_scan("pre_rst", 34'd16, 2'd1, 32'd9);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check_eq("mid_dir", 64'(dir), 64'd1);
    RESET_L = 1'b0;
    #1;
    check_eq("ar_busy",  64'(BUSY), 64'd0);
    check_eq("ar_dir",   64'(dir), 64'd0);
    check_eq("ar_le",    64'(LE), 64'd1);
    check_eq("ar_total", 64'(TOTAL), 64'd0);
    check_eq("ar_val",   64'(MAX_VAL), 64'd0);
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    check_eq("ar_m1", 64'(mem[1]), 64'd9);
    check_eq("ar_m2", 64'(mem[2]), 64'd2);
    load_mem(32'd5, 32'd9, 32'd2);
    run_scan("post_rst", 34'd16, 2'd1, 32'd9);

    // START pulsed mid-scan must be ignored
    load_mem(32'd1, 32'd2, 32'd3);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    check_eq("ign_busy", 64'(BUSY), 64'd1);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) dones++;
      @(posedge CLK); #1;
    end
    check_eq("ign_dones", 64'(dones), 64'd1);
    check_eq("ign_total", 64'(TOTAL), 64'd6);

    // START held: back-to-back scans
    load_mem(32'd1, 32'd2, 32'd3);
    START = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        if (t1 < 0) t1 = i;
        else t2 = i;
      end
    end
    START = 1'b0;
    check_eq("held_gap", 64'(t2 - t1), 64'(GAP));
    repeat (30) @(posedge CLK);
    #1;
    check_eq("held_idle", 64'(BUSY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
